alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequencer for an external ALU on a shared tri-state data bus.
//
// Each accepted request runs as a short bus sequence:
//   LOAD : write operand b into the ALU              (alu_wr, alu_op = 0)
//   EXEC : write operand a together with the opcode   (alu_wr, alu_op = 1,alt,f3)
//   READ : read the result back over the bus          (alu_rd)
//   RESP : hold the result until the consumer takes it
// The ALU keeps its result as an accumulator. With operand chaining enabled
// a request can skip LOAD and use that accumulator as operand b.
//
// Build option:
//   ALU_SEQ_CHAIN_EN  when defined, req_use_acc=1 takes the IDLE->EXEC path.
//                     When undefined, req_use_acc is ignored and every
//                     operation goes through LOAD.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_funct3, req_funct7b5   RISC-V funct3 and funct7 bit 5
//   req_a, req_b               operands rs1, rs2
//   req_use_acc                use ALU accumulator as operand b
//   rsp_valid / rsp_ready      response handshake, rsp_data = result
//   alu_wr, alu_rd, alu_op     ALU bus control strobes
//   bus                        shared 32-bit tri-state data bus
//   ops_done                   count of completed responses (wraps)
// ---------------------------------------------------------------------------
module alu_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic        req_funct7b5,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_use_acc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        alu_wr,
   output logic        alu_rd,
   output logic [4:0]  alu_op,
   inout  wire  [31:0] bus,
   output logic [15:0] ops_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EXEC,
      S_READ,
      S_RESP
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [2:0]  funct3_q;
   logic        funct7b5_q;
   logic        use_acc_q;

   logic        accept;
   logic        rsp_done;
   logic        bus_en;
   logic [31:0] bus_out;
   logic        alt_op;

   // req_ready is forced low while reset is held, even though state is IDLE.
   assign req_ready = (state == S_IDLE) && rst_n;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == S_RESP);
   assign rsp_done  = rsp_valid && rsp_ready;

   // funct7 bit 5 only selects sub/sra; it is a don't-care for other funct3.
   assign alt_op = funct7b5_q && ((funct3_q == 3'b000) || (funct3_q == 3'b101));

   assign bus = bus_en ? bus_out : 'z;

   // The path decision is taken at acceptance from req_use_acc directly; the
   // registered copy is kept with the request for observability only.
   logic unused_use_acc;
   assign unused_use_acc = use_acc_q;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
`ifdef ALU_SEQ_CHAIN_EN
               state_nxt = req_use_acc ? S_EXEC : S_LOAD;
`else
               state_nxt = S_LOAD;
`endif
            end
         end
         S_LOAD:  state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_READ;
         S_READ:  state_nxt = S_RESP;
         S_RESP:  if (rsp_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode -- strobes and bus enable depend on the current state only
   // ------------------------------------------------------------------------
   always_comb begin
      alu_wr  = 1'b0;
      alu_rd  = 1'b0;
      alu_op  = 5'b00000;
      bus_en  = 1'b0;
      bus_out = '0;
      unique case (state)
         S_LOAD: begin
            alu_wr  = 1'b1;
            bus_en  = 1'b1;
            bus_out = b_q;
         end
         S_EXEC: begin
            alu_wr  = 1'b1;
            alu_op  = {1'b1, alt_op, funct3_q};
            bus_en  = 1'b1;
            bus_out = a_q;
         end
         S_READ: begin
            alu_rd  = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Request capture, result capture and completion counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
         use_acc_q  <= 1'b0;
         rsp_data   <= '0;
         ops_done   <= '0;
      end else begin
         if (accept) begin
            a_q        <= req_a;
            b_q        <= req_b;
            funct3_q   <= req_funct3;
            funct7b5_q <= req_funct7b5;
            use_acc_q  <= req_use_acc;
         end
         // The ALU drives the bus during READ; its value is taken at the
         // edge that leaves READ and then held through RESP.
         if (state == S_READ) begin
            rsp_data <= bus;
         end
         if (rsp_done) begin
            ops_done <= ops_done + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq.
// Contains a behavioural ALU attached to the bus (operand/accumulator
// register, answers alu_rd), a directed vector table, random operations
// checked against a reference computed from the RISC-V operation rules,
// a backpressure sequence and a reset-during-EXEC sequence.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic        req_funct7b5;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        req_use_acc;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        alu_wr;
   logic        alu_rd;
   logic [4:0]  alu_op;
   wire  [31:0] bus;
   logic [15:0] ops_done;

   int          n_vectors;
   int          n_miscompares;
   logic [15:0] exp_ops;

   alu_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_funct3   (req_funct3),
      .req_funct7b5 (req_funct7b5),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_use_acc  (req_use_acc),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .alu_wr       (alu_wr),
      .alu_rd       (alu_rd),
      .alu_op       (alu_op),
      .bus          (bus),
      .ops_done     (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ----------------------------------------------------------------------
   // Behavioural ALU on the bus: op 0 loads operand b into the accumulator,
   // op 1xxxx combines the bus (operand a) with the accumulator.
   // ----------------------------------------------------------------------
   logic [31:0] alu_acc;

   function automatic logic [31:0] alu_compute(input logic [4:0] op,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
      logic [31:0] r;
      r = '0;
      case (op[2:0])
         3'd0: r = op[3] ? (x - y) : (x + y);
         3'd1: r = x << y[4:0];
         3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd3: r = (x < y) ? 32'd1 : 32'd0;
         3'd4: r = x ^ y;
         3'd5: begin
            if (op[3]) r = $signed(x) >>> y[4:0];
            else       r = x >> y[4:0];
         end
         3'd6: r = x | y;
         default: r = x & y;
      endcase
      return r;
   endfunction

   assign bus = alu_rd ? alu_acc : 'z;

   always @(posedge clk) begin
      if (alu_wr) begin
         if (alu_op[4]) alu_acc <= alu_compute(alu_op, bus, alu_acc);
         else           alu_acc <= bus;
      end
   end

   logic bus_z;
   assign bus_z = (bus === 32'hzzzz_zzzz);

   // ----------------------------------------------------------------------
   // Reference: result and opcode straight from the RISC-V rules.
   // ----------------------------------------------------------------------
   function automatic logic [31:0] ref_result(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0] f3,
                                              input logic f7b5);
      int unsigned sh;
      logic [31:0] r;
      sh = int'(b % 32);
      r = '0;
      if (f3 == 3'd0) begin
         if (f7b5) r = a + (~b + 32'd1);
         else      r = a + b;
      end else if (f3 == 3'd1) r = a * (32'd1 << sh);
      else if (f3 == 3'd2) r = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
      else if (f3 == 3'd3) r = (a < b) ? 32'd1 : 32'd0;
      else if (f3 == 3'd4) r = a ^ b;
      else if (f3 == 3'd5) begin
         r = a >> sh;
         if (f7b5 && a[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
      end else if (f3 == 3'd6) r = a | b;
      else r = a & b;
      return r;
   endfunction

   function automatic logic [4:0] ref_op(input logic [2:0] f3, input logic f7b5);
      logic alt;
      alt = f7b5 && (f3 == 3'd0 || f3 == 3'd5);
      return {1'b1, alt, f3};
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vectors++;
      if (act !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ----------------------------------------------------------------------
   // One complete operation: request, bus sequence, optional stall, response.
   // ----------------------------------------------------------------------
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic f7b5,
                        input logic use_acc, input int stall,
                        input logic [31:0] exp_data, input logic [4:0] exp_op,
                        input int exp_lat, input logic exp_load,
                        input string tag);
      int          cyc;
      logic        saw_load;
      logic [4:0]  seen_op;
      logic        got;
      @(negedge clk);
      check({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_a        = a;
      req_b        = b;
      req_funct3   = f3;
      req_funct7b5 = f7b5;
      req_use_acc  = use_acc;
      rsp_ready    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs: the sequencer must work from its registered copy.
      req_valid    = 1'b0;
      req_a        = $urandom;
      req_b        = $urandom;
      req_funct3   = 3'($urandom_range(0, 7));
      req_funct7b5 = 1'($urandom_range(0, 1));
      cyc = 1;
      saw_load = 1'b0;
      seen_op = '0;
      got = 1'b0;
      while (cyc <= 12) begin
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
         check({tag, "/busy_not_ready"}, 32'(req_ready), 32'd0);
         check({tag, "/wr_rd_excl"}, 32'(alu_wr & alu_rd), 32'd0);
         if (alu_wr && alu_op == 5'd0) begin
            saw_load = 1'b1;
            check({tag, "/load_bus"}, bus, b);
         end
         if (alu_wr && alu_op[4]) begin
            seen_op = alu_op;
            check({tag, "/exec_bus"}, bus, a);
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      check({tag, "/rsp_timeout"}, 32'(got), 32'd1);
      check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, "/alu_op"}, 32'(seen_op), 32'(exp_op));
      check({tag, "/load_phase"}, 32'(saw_load), 32'(exp_load));
      check({tag, "/rsp_data"}, rsp_data, exp_data);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "/stall_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "/stall_data"}, rsp_data, exp_data);
         check({tag, "/stall_ready"}, 32'(req_ready), 32'd0);
         check({tag, "/stall_strobes"}, 32'({alu_wr, alu_rd}), 32'd0);
         check({tag, "/stall_bus_z"}, 32'(bus_z), 32'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_ops = exp_ops + 16'd1;
      check({tag, "/rsp_cleared"}, 32'(rsp_valid), 32'd0);
      check({tag, "/ops_done"}, 32'(ops_done), 32'(exp_ops));
      check({tag, "/back_idle"}, 32'(req_ready), 32'd1);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f3;
      logic        f7b5;
      int          stall;
      logic [31:0] exp_data;
      logic [4:0]  exp_op;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rf3;
      logic        rf7;
      logic        rua;

      n_vectors     = 0;
      n_miscompares = 0;
      exp_ops       = '0;
      alu_acc       = '0;

      vecs[0] = '{32'd5,         32'd7,         3'b000, 1'b0, 0, 32'h0000_000C, 5'b10000};
      vecs[1] = '{32'd3,         32'd5,         3'b000, 1'b1, 0, 32'hFFFF_FFFE, 5'b11000};
      vecs[2] = '{32'd1,         32'hFFFF_FFFF, 3'b011, 1'b0, 0, 32'h0000_0001, 5'b10011};
      vecs[3] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 1'b1, 5, 32'hFF00_FF00, 5'b10100};
      vecs[4] = '{32'h8000_0000, 32'd4,         3'b101, 1'b1, 0, 32'hF800_0000, 5'b11101};
      vecs[5] = '{32'h8000_0000, 32'd4,         3'b101, 1'b0, 1, 32'h0800_0000, 5'b10101};
      vecs[6] = '{32'd1,         32'h0000_0025, 3'b001, 1'b1, 0, 32'h0000_0020, 5'b10001};
      vecs[7] = '{32'hFFFF_FFFF, 32'd1,         3'b010, 1'b0, 0, 32'h0000_0001, 5'b10010};
      vecs[8] = '{32'h0000_000F, 32'h0000_00F0, 3'b110, 1'b0, 2, 32'h0000_00FF, 5'b10110};
      vecs[9] = '{32'hFFFF_0000, 32'h1234_5678, 3'b111, 1'b1, 0, 32'h1234_0000, 5'b10111};

      req_valid    = 1'b0;
      req_a        = '0;
      req_b        = '0;
      req_funct3   = '0;
      req_funct7b5 = 1'b0;
      req_use_acc  = 1'b0;
      rsp_ready    = 1'b0;
      rst_n        = 1'b0;

      // Reset state
      #2;
      check("rst/req_ready_low", 32'(req_ready), 32'd0);
      check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst/rsp_data", rsp_data, 32'd0);
      check("rst/ops_done", 32'(ops_done), 32'd0);
      check("rst/strobes", 32'({alu_wr, alu_rd}), 32'd0);
      check("rst/alu_op", 32'(alu_op), 32'd0);
      check("rst/bus_z", 32'(bus_z), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst/req_ready_high", 32'(req_ready), 32'd1);

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].f7b5, 1'b0,
               vecs[i].stall, vecs[i].exp_data, vecs[i].exp_op, 4, 1'b1,
               $sformatf("vec%0d", i));
      end

      // Accumulator chaining / use_acc handling
      do_op(32'd5, 32'd7, 3'b000, 1'b0, 1'b0, 0, 32'h0000_000C, 5'b10000, 4,
            1'b1, "chain_seed");
`ifdef ALU_SEQ_CHAIN_EN
      do_op(32'd20, 32'hDEAD_BEEF, 3'b000, 1'b1, 1'b1, 0, 32'h0000_0008,
            5'b11000, 3, 1'b0, "chain_sub");
`else
      do_op(32'd20, 32'd4, 3'b000, 1'b1, 1'b1, 0, 32'h0000_0010,
            5'b11000, 4, 1'b1, "use_acc_ignored");
`endif

      // Random operations against the reference
      for (int i = 0; i < 40; i++) begin
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         rf3 = 3'($urandom_range(0, 7));
         rf7 = 1'($urandom_range(0, 1));
         rua = 1'b0;
`ifndef ALU_SEQ_CHAIN_EN
         rua = 1'($urandom_range(0, 1));
`endif
         do_op(ra, rb, rf3, rf7, rua, $urandom_range(0, 3),
               ref_result(ra, rb, rf3, rf7), ref_op(rf3, rf7), 4, 1'b1,
               $sformatf("rnd%0d", i));
      end

      // Reset asserted while in EXEC
      @(negedge clk);
      req_valid    = 1'b1;
      req_a        = 32'd100;
      req_b        = 32'd1;
      req_funct3   = 3'b000;
      req_funct7b5 = 1'b0;
      req_use_acc  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rstx/in_exec", 32'(alu_op[4] & alu_wr), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rstx/strobes", 32'({alu_wr, alu_rd}), 32'd0);
      check("rstx/bus_z", 32'(bus_z), 32'd1);
      check("rstx/rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstx/ops_done", 32'(ops_done), 32'd0);
      check("rstx/req_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_ops = '0;
      #1;
      check("rstx/req_ready_high", 32'(req_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rstx/no_rsp", 32'(rsp_valid), 32'd0);
         check("rstx/idle_strobes", 32'({alu_wr, alu_rd}), 32'd0);
      end
      do_op(32'd9, 32'd6, 3'b000, 1'b1, 1'b0, 1, 32'd3, 5'b11000, 4, 1'b1,
            "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
